// File: rtl/regfile_scoreboard.sv
// Register file with per-register lock bits and per-port read FSMs that stall on locked registers.
// Latency: unlocked read 1 cycle; a waiting read returns 1 cycle after the releasing write with REGFILE_BYPASS_EN defined, otherwise 2.
// Backpressure: lock requests to a locked register are denied (requester retries); reads to locked registers hold in WAIT with rd_busy_o high.
module regfile_scoreboard #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 5,
    parameter int NumRead   = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumRead-1:0]             rd_req_i,
    input  logic [NumRead*AddrWidth-1:0]   rd_addr_i,
    output logic [NumRead-1:0]             rd_valid_o,
    output logic [NumRead*DataWidth-1:0]   rd_data_o,
    output logic [NumRead-1:0]             rd_busy_o,
    input  logic                           lock_req_i,
    input  logic [AddrWidth-1:0]           lock_addr_i,
    output logic                           lock_gnt_o,
    input  logic                           wr_alu_en_i,
    input  logic [AddrWidth-1:0]           wr_alu_addr_i,
    input  logic [DataWidth-1:0]           wr_alu_data_i,
    input  logic                           wr_lsu_en_i,
    input  logic [AddrWidth-1:0]           wr_lsu_addr_i,
    input  logic [DataWidth-1:0]           wr_lsu_data_i,
    output logic [2**AddrWidth-1:0]        locked_o
);

    localparam int Depth = 2**AddrWidth;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } rd_state_e;

    logic [DataWidth-1:0] mem_q [Depth];
    logic [DataWidth-1:0] mem_d [Depth];
    logic [Depth-1:0]     locked_q;
    logic [Depth-1:0]     locked_d;

    // Writes to x0 are dropped here so nothing downstream has to special-case them.
    logic alu_wr;
    logic lsu_wr;
    logic lock_hit;

    assign alu_wr   = wr_alu_en_i && (wr_alu_addr_i != '0);
    assign lsu_wr   = wr_lsu_en_i && (wr_lsu_addr_i != '0);
    assign lock_hit = (alu_wr && (wr_alu_addr_i == lock_addr_i)) ||
                      (lsu_wr && (wr_lsu_addr_i == lock_addr_i));

    // A lock is granted when the target is x0, free, or being released this very cycle.
    assign lock_gnt_o = !rst_i && lock_req_i &&
                        ((lock_addr_i == '0) || !locked_q[lock_addr_i] || lock_hit);

    assign locked_o = locked_q;

    // Next register contents and lock bits: LSU applied after ALU so it wins, lock set applied last so it survives a same-cycle write.
    always_comb begin
        mem_d    = mem_q;
        locked_d = locked_q;
        if (alu_wr) begin
            mem_d[wr_alu_addr_i]    = wr_alu_data_i;
            locked_d[wr_alu_addr_i] = 1'b0;
        end
        if (lsu_wr) begin
            mem_d[wr_lsu_addr_i]    = wr_lsu_data_i;
            locked_d[wr_lsu_addr_i] = 1'b0;
        end
        if (lock_gnt_o && (lock_addr_i != '0)) begin
            locked_d[lock_addr_i] = 1'b1;
        end
    end

    // Register file and lock bit storage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            locked_q <= '0;
        end else begin
            mem_q    <= mem_d;
            locked_q <= locked_d;
        end
    end

    genvar k;
    for (k = 0; k < NumRead; k++) begin : g_rd
        rd_state_e            state_q, state_d;
        logic                 valid_q, valid_d;
        logic [DataWidth-1:0] data_q,  data_d;
        logic [AddrWidth-1:0] addr_q,  addr_d;
        logic                 pend_q,  pend_d;

        logic [AddrWidth-1:0] req_addr;
        logic                 req_locked;
        logic [DataWidth-1:0] req_src;
        logic                 wait_alu, wait_lsu, wait_hit;
        logic                 release_now;
        logic [DataWidth-1:0] wait_src;
`ifdef REGFILE_BYPASS_EN
        logic                 req_alu, req_lsu;
`endif

        assign req_addr = rd_addr_i[k*AddrWidth +: AddrWidth];

        // Decide whether each candidate read is blocked and where its data comes from.
        always_comb begin
            wait_alu = alu_wr && (wr_alu_addr_i == addr_q);
            wait_lsu = lsu_wr && (wr_lsu_addr_i == addr_q);
            wait_hit = wait_alu || wait_lsu;
`ifdef REGFILE_BYPASS_EN
            req_alu     = alu_wr && (wr_alu_addr_i == req_addr);
            req_lsu     = lsu_wr && (wr_lsu_addr_i == req_addr);
            req_locked  = locked_q[req_addr] && !(req_alu || req_lsu);
            req_src     = req_lsu ? wr_lsu_data_i :
                          req_alu ? wr_alu_data_i : mem_q[req_addr];
            release_now = wait_hit || pend_q || !locked_q[addr_q];
            wait_src    = wait_lsu ? wr_lsu_data_i :
                          wait_alu ? wr_alu_data_i : mem_q[addr_q];
`else
            // pend_q remembers a releasing write whose lock was re-taken in the same cycle.
            req_locked  = locked_q[req_addr];
            req_src     = mem_q[req_addr];
            release_now = pend_q || !locked_q[addr_q];
            wait_src    = mem_q[addr_q];
`endif
        end

        // Read port state register; reset abandons any pending read silently.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                data_q  <= '0;
                addr_q  <= '0;
                pend_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                valid_q <= valid_d;
                data_q  <= data_d;
                addr_q  <= addr_d;
                pend_q  <= pend_d;
            end
        end

        // Next state: park in WAIT on a locked address until it is released.
        always_comb begin
            state_d = state_q;
            case (state_q)
                IDLE: if (rd_req_i[k] && req_locked) state_d = WAIT;
                WAIT: if (release_now) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Outputs: valid pulse and held data, captured address for the wait.
        always_comb begin
            valid_d = 1'b0;
            data_d  = data_q;
            addr_d  = addr_q;
            pend_d  = 1'b0;
            case (state_q)
                IDLE: begin
                    if (rd_req_i[k]) begin
                        if (req_locked) begin
                            addr_d = req_addr;
                        end else begin
                            valid_d = 1'b1;
                            data_d  = req_src;
                        end
                    end
                end
                WAIT: begin
                    if (release_now) begin
                        valid_d = 1'b1;
                        data_d  = wait_src;
                    end else begin
                        pend_d = pend_q || wait_hit;
                    end
                end
                default: valid_d = 1'b0;
            endcase
        end

        assign rd_valid_o[k]                       = valid_q;
        assign rd_busy_o[k]                        = (state_q == WAIT);
        assign rd_data_o[k*DataWidth +: DataWidth] = data_q;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with default parameters (2 read ports, 32 x 32-bit).
// Each vector is applied for one cycle; grant is checked before the edge, registered outputs after.
// Latency-dependent expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic [1:0]  rd_req;
    logic [9:0]  rd_addr;
    logic [1:0]  rd_valid;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        lk_req;
    logic [4:0]  lk_addr;
    logic        lk_gnt;
    logic        alu_en;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        lsu_en;
    logic [4:0]  lsu_addr;
    logic [31:0] lsu_data;
    logic [31:0] locked;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        rst;
        logic [1:0]  rd_req;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        lk_req;
        logic [4:0]  lk_addr;
        logic        alu_en;
        logic [4:0]  alu_addr;
        logic [31:0] alu_data;
        logic        lsu_en;
        logic [4:0]  lsu_addr;
        logic [31:0] lsu_data;
        logic        e_gnt;
        logic [1:0]  e_valid;
        logic [1:0]  e_busy;
        logic [31:0] e_locked;
        logic [1:0]  dmask;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
    } vec_t;

    regfile_scoreboard #(
        .DataWidth(32),
        .AddrWidth(5),
        .NumRead(2)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rd_req_i     (rd_req),
        .rd_addr_i    (rd_addr),
        .rd_valid_o   (rd_valid),
        .rd_data_o    (rd_data),
        .rd_busy_o    (rd_busy),
        .lock_req_i   (lk_req),
        .lock_addr_i  (lk_addr),
        .lock_gnt_o   (lk_gnt),
        .wr_alu_en_i  (alu_en),
        .wr_alu_addr_i(alu_addr),
        .wr_alu_data_i(alu_data),
        .wr_lsu_en_i  (lsu_en),
        .wr_lsu_addr_i(lsu_addr),
        .wr_lsu_data_i(lsu_data),
        .locked_o     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string nm);
        @(negedge clk);
        rst      = v.rst;
        rd_req   = v.rd_req;
        rd_addr  = {v.ra1, v.ra0};
        lk_req   = v.lk_req;
        lk_addr  = v.lk_addr;
        alu_en   = v.alu_en;
        alu_addr = v.alu_addr;
        alu_data = v.alu_data;
        lsu_en   = v.lsu_en;
        lsu_addr = v.lsu_addr;
        lsu_data = v.lsu_data;
        #1;
        chk({nm, " gnt"}, 32'(lk_gnt), 32'(v.e_gnt));
        @(posedge clk);
        #1;
        chk({nm, " valid"}, 32'(rd_valid), 32'(v.e_valid));
        chk({nm, " busy"}, 32'(rd_busy), 32'(v.e_busy));
        chk({nm, " locked"}, locked, v.e_locked);
        if (v.dmask[0]) chk({nm, " data0"}, rd_data[31:0], v.e_d0);
        if (v.dmask[1]) chk({nm, " data1"}, rd_data[63:32], v.e_d1);
    endtask

    vec_t tbl [15];
    vec_t v;

    initial begin
        rst = 1'b1; rd_req = '0; rd_addr = '0; lk_req = 1'b0; lk_addr = '0;
        alu_en = 1'b0; alu_addr = '0; alu_data = '0; lsu_en = 1'b0; lsu_addr = '0; lsu_data = '0;

        //            rst   rdreq  ra0    ra1    lkreq lkaddr alu   aaddr  adata          lsu   laddr  ldata       gnt   valid  busy   locked        dmask  d0             d1
        tbl[0]  = '{1'b1, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 2'b00, 2'b00, 32'h0,        2'b11, 32'h0,        32'h0};
        tbl[1]  = '{1'b1, 2'b01, 5'd5, 5'd0, 1'b1, 5'd4, 1'b1, 5'd5, 32'hAAAA,     1'b0, 5'd0, 32'h0,  1'b0, 2'b00, 2'b00, 32'h0,        2'b11, 32'h0,        32'h0};
        tbl[2]  = '{1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 2'b00, 2'b00, 32'h0,        2'b00, 32'h0,        32'h0};
        tbl[3]  = '{1'b0, 2'b01, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 2'b01, 2'b00, 32'h0,        2'b01, 32'hDEADBEEF, 32'h0};
        tbl[4]  = '{1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 2'b00, 2'b00, 32'h0,        2'b01, 32'hDEADBEEF, 32'h0};
        tbl[5]  = '{1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 32'h0,  1'b1, 2'b00, 2'b00, 32'h0,        2'b00, 32'h0,        32'h0};
        tbl[6]  = '{1'b0, 2'b10, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 2'b10, 2'b00, 32'h0,        2'b10, 32'h0,        32'h0};
        tbl[7]  = '{1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 2'b00, 2'b00, 32'h8,        2'b00, 32'h0,        32'h0};
        tbl[8]  = '{1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'h11,       1'b1, 5'd3, 32'h22, 1'b0, 2'b00, 2'b00, 32'h0,        2'b00, 32'h0,        32'h0};
        tbl[9]  = '{1'b0, 2'b11, 5'd3, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 2'b11, 2'b00, 32'h0,        2'b11, 32'h22,       32'h22};
        tbl[10] = '{1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 2'b00, 2'b00, 32'h200,      2'b00, 32'h0,        32'h0};
        tbl[11] = '{1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 2'b00, 2'b00, 32'h200,      2'b00, 32'h0,        32'h0};
        tbl[12] = '{1'b0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 32'h0,  1'b1, 2'b00, 2'b00, 32'h200,      2'b00, 32'h0,        32'h0};
        tbl[13] = '{1'b0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h77, 1'b0, 2'b00, 2'b00, 32'h0,        2'b00, 32'h0,        32'h0};
        tbl[14] = '{1'b0, 2'b11, 5'd3, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 2'b11, 2'b00, 32'h0,        2'b11, 32'h22,       32'h77};

        for (int i = 0; i < 15; i++) begin
            step(tbl[i], $sformatf("tbl%0d", i));
        end

        // Lock x7, both ports wait on it, LSU releases it three cycles later.
        v = '0; v.lk_req = 1'b1; v.lk_addr = 5'd7; v.e_gnt = 1'b1; v.e_locked = 32'h80;
        step(v, "w_lock");
        v = '0; v.rd_req = 2'b11; v.ra0 = 5'd7; v.ra1 = 5'd7; v.e_busy = 2'b11; v.e_locked = 32'h80;
        step(v, "w_req");
        v = '0; v.e_busy = 2'b11; v.e_locked = 32'h80;
        step(v, "w_hold1");
        step(v, "w_hold2");
        v = '0; v.lsu_en = 1'b1; v.lsu_addr = 5'd7; v.lsu_data = 32'h55;
`ifdef REGFILE_BYPASS_EN
        v.e_valid = 2'b11; v.dmask = 2'b11; v.e_d0 = 32'h55; v.e_d1 = 32'h55;
`else
        v.e_busy = 2'b11;
`endif
        step(v, "w_release");
        v = '0; v.dmask = 2'b11; v.e_d0 = 32'h55; v.e_d1 = 32'h55;
`ifndef REGFILE_BYPASS_EN
        v.e_valid = 2'b11;
`endif
        step(v, "w_after1");
        v = '0; v.dmask = 2'b11; v.e_d0 = 32'h55; v.e_d1 = 32'h55;
        step(v, "w_after2");

        // Reset while port 1 waits: read is abandoned and everything clears.
        v = '0; v.lk_req = 1'b1; v.lk_addr = 5'd12; v.e_gnt = 1'b1; v.e_locked = 32'h1000;
        step(v, "r_lock");
        v = '0; v.rd_req = 2'b10; v.ra1 = 5'd12; v.e_busy = 2'b10; v.e_locked = 32'h1000;
        v.dmask = 2'b11; v.e_d0 = 32'h55; v.e_d1 = 32'h55;
        step(v, "r_wait");
        v = '0; v.rst = 1'b1; v.lk_req = 1'b1; v.lk_addr = 5'd2; v.dmask = 2'b11;
        step(v, "r_reset");
        v = '0; v.alu_en = 1'b1; v.alu_addr = 5'd12; v.alu_data = 32'h3; v.dmask = 2'b11;
        step(v, "r_write");
        v = '0; v.dmask = 2'b11;
        step(v, "r_quiet");
        v = '0; v.rd_req = 2'b01; v.ra0 = 5'd5; v.e_valid = 2'b01; v.dmask = 2'b01;
        step(v, "r_memclr");

        // Read of an address written in the same cycle.
        v = '0; v.rd_req = 2'b01; v.ra0 = 5'd5; v.alu_en = 1'b1; v.alu_addr = 5'd5; v.alu_data = 32'hCAFE;
        v.e_valid = 2'b01; v.dmask = 2'b01;
`ifdef REGFILE_BYPASS_EN
        v.e_d0 = 32'hCAFE;
`endif
        step(v, "s_same");
        v = '0; v.rd_req = 2'b01; v.ra0 = 5'd5; v.e_valid = 2'b01; v.dmask = 2'b01; v.e_d0 = 32'hCAFE;
        step(v, "s_next");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DataWidth, default 32: register width in bits.
REQ-002 SHALL have parameter AddrWidth, default 5: address width; depth = 2**AddrWidth.
REQ-003 SHALL have parameter NumRead, default 2: number of independent read ports, 1..4.
REQ-004 SHALL have ports, in this order:
- clk_i, in, 1: single clock; all state updates on its rising edge.
- rst_i, in, 1: reset, synchronous, active-high.
- rd_req_i, in, NumRead: per-port read request, one-cycle pulse.
- rd_addr_i, in, NumRead*AddrWidth: per-port read address; port k uses slice k.
- rd_valid_o, out, NumRead: per-port read data valid, one-cycle pulse.
- rd_data_o, out, NumRead*DataWidth: per-port read data, held until the next valid.
- rd_busy_o, out, NumRead: port is waiting on a locked register.
- lock_req_i, in, 1: reserve a destination register.
- lock_addr_i, in, AddrWidth: register to reserve.
- lock_gnt_o, out, 1: reservation accepted; combinational.
- wr_alu_en_i / wr_alu_addr_i / wr_alu_data_i, in, 1 / AddrWidth / DataWidth: ALU write port.
- wr_lsu_en_i / wr_lsu_addr_i / wr_lsu_data_i, in, 1 / AddrWidth / DataWidth: LSU write port.
- locked_o, out, 2**AddrWidth: per-register lock bits.

Function
REQ-005 SHALL hardwire register 0 to zero; writes to it are ignored and it never locks.
REQ-006 SHALL write wdata to mem[waddr] at the clock edge for each enabled write port; if both ports target the same address, the LSU data SHALL win.
REQ-007 SHALL clear locked[waddr] on any enabled write to waddr.
REQ-008 SHALL assert lock_gnt_o when lock_req_i=1 and either lock_addr_i=0 or locked[lock_addr_i]=0 or a write to lock_addr_i occurs in the same cycle.
REQ-009 SHALL set locked[lock_addr_i] at the edge when granted and lock_addr_i!=0; a lock and a write to the same address in one cycle SHALL leave the bit set.
REQ-010 SHALL hold locked state unchanged when lock_req_i=1 and the grant is denied; the requester retries.
REQ-011 SHALL implement one FSM per read port with states IDLE and WAIT.
REQ-012 IDLE with rd_req_i=1 and the address unlocked SHALL register mem[addr] into rd_data_o and pulse rd_valid_o in the next cycle (latency 1); the FSM stays IDLE.
REQ-013 IDLE with rd_req_i=1 and the address locked SHALL capture the address, go to WAIT and assert rd_busy_o from the next cycle.
REQ-014 WAIT SHALL ignore rd_req_i, and SHALL leave on release of the captured address by pulsing rd_valid_o with the released value and returning to IDLE.
REQ-015 SHALL serve read ports independently; several ports SHALL be able to read or wait on the same address at once.
REQ-016 SHALL keep rd_data_o stable between rd_valid_o pulses.

Reset
REQ-017 rst_i=1 SHALL at the edge clear all registers to 0, all locked bits, and all rd_valid_o, rd_busy_o and rd_data_o, and SHALL return every FSM to IDLE.
REQ-018 Reset asserted while a port is in WAIT SHALL abandon the read with no rd_valid_o pulse.
REQ-019 While rst_i=1, SHALL force lock_gnt_o to 0 and ignore writes and reads.

Configuration
REQ-020 Macro REGFILE_BYPASS_EN defined SHALL forward same-cycle write data to reads:
- An IDLE request whose address is written that cycle SHALL be treated as unlocked and SHALL return the new data (LSU data if both ports write it), latency 1.
- A WAIT port SHALL return data 1 cycle after the releasing write edge.
REQ-021 Macro REGFILE_BYPASS_EN undefined SHALL read mem only:
- An IDLE request to an address written in the same cycle SHALL return the old value, or wait if that address is locked.
- A WAIT port SHALL return data 2 cycles after the releasing write edge.

Verification
REQ-022 Bench SHALL cover: write ALU x5=0xDEADBEEF, then read port 0 x5 -> rd_valid_o[0] 1 cycle later with 0xDEADBEEF.
REQ-023 Bench SHALL cover: write x0=0x1234 and lock x0 -> lock_gnt_o=1, locked_o[0]=0, a read of x0 returns 0.
REQ-024 Bench SHALL cover: lock x7, both ports read x7, LSU writes 0x55 three cycles later -> both rd_busy_o=1 until the write, then both return 0x55 at latency per REQ-020/021.
REQ-025 Bench SHALL cover: ALU and LSU write x3 in the same cycle (0x11 / 0x22) -> mem[3]=0x22 and locked[3] cleared.
REQ-026 Bench SHALL cover: relock of locked x9 -> gnt=0; relock of x9 in the same cycle as a write to x9 -> gnt=1 and locked_o[9] stays 1.
REQ-027 Bench SHALL cover: rst_i pulse while port 1 is in WAIT -> no rd_valid_o, all outputs 0, all locks clear.
